// File: rtl/multicycle_control_unit.sv
// Multi-cycle Moore control unit: FETCH/DECODE/EXEC/MEM/WB sequencing with a bounded memory wait.
// Define ILLEGAL_OP_TRAP_EN to trap illegal opcodes into HALT and expose the sticky illegal_op flag.
module multicycle_control_unit #(
   parameter int OPCODE_W = 4,
   parameter int WAIT_MAX = 15
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [OPCODE_W-1:0] OPCODE,
   input  logic                mem_ready,
   output logic                PCWrite,
   output logic                Branch,
   output logic                PCSource,
   output logic                IorD,
   output logic                IRWrite,
   output logic                MemRead,
   output logic                MemWrite,
   output logic                MemtoReg,
   output logic                RegDest,
   output logic                RegWrite,
   output logic                ALUSrcA,
   output logic [1:0]          ALUSrcB,
   output logic [1:0]          ALUOp,
   output logic                instr_done,
   output logic                mem_err,
`ifdef ILLEGAL_OP_TRAP_EN
   output logic                illegal_op,
`endif
   output logic [2:0]          state
);

   typedef enum logic [2:0] {
      S_RST    = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_HALT   = 3'd6
   } state_t;

   typedef enum logic [2:0] {
      C_R, C_I, C_LW, C_SW, C_BEQ, C_ILL
   } cls_t;

   localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

   state_t                state_q;
   state_t                next_state;
   logic [OPCODE_W-1:0]   op_q;
   logic [CW-1:0]         wait_cnt;
   logic                  mem_err_q;
   logic                  waiting;
   logic                  timeout;
   cls_t                  cls;

   assign state   = state_q;
   assign mem_err = mem_err_q;
   assign waiting = (state_q == S_FETCH) || (state_q == S_MEM);
   assign timeout = (WAIT_MAX > 0) && waiting && !mem_ready && (wait_cnt == CW'(WAIT_MAX));

   // Any nonzero bit above the low nibble makes the opcode illegal.
   always_comb begin
      cls = C_ILL;
      if ((op_q >> 4) == '0) begin
         case (op_q[3:0])
            4'b0000, 4'b0001, 4'b0010: cls = C_R;
            4'b1001, 4'b1010, 4'b1011: cls = C_I;
            4'b1100:                   cls = C_LW;
            4'b1101:                   cls = C_SW;
            4'b1111:                   cls = C_BEQ;
            default:                   cls = C_ILL;
         endcase
      end
   end

   always_comb begin
      next_state = state_q;
      PCWrite    = 1'b0;
      Branch     = 1'b0;
      PCSource   = 1'b0;
      IorD       = 1'b0;
      IRWrite    = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      MemtoReg   = 1'b0;
      RegDest    = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      instr_done = 1'b0;
      case (state_q)
         S_RST: next_state = S_FETCH;
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = mem_ready;
            PCWrite = mem_ready;
            if (mem_ready)    next_state = S_DECODE;
            else if (timeout) next_state = S_HALT;
         end
         S_DECODE: begin
            ALUSrcB    = 2'b11;
            next_state = S_EXEC;
         end
         S_EXEC: begin
            case (cls)
               C_R: begin
                  ALUSrcA    = 1'b1;
                  ALUOp      = 2'b10;
                  next_state = S_WB;
               end
               C_I: begin
                  ALUSrcA    = 1'b1;
                  ALUSrcB    = 2'b10;
                  ALUOp      = 2'b11;
                  next_state = S_WB;
               end
               C_LW, C_SW: begin
                  ALUSrcA    = 1'b1;
                  ALUSrcB    = 2'b10;
                  next_state = S_MEM;
               end
               C_BEQ: begin
                  ALUSrcA    = 1'b1;
                  ALUOp      = 2'b01;
                  Branch     = 1'b1;
                  PCSource   = 1'b1;
                  instr_done = 1'b1;
                  next_state = S_FETCH;
               end
               default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                  next_state = S_HALT;
`else
                  instr_done = 1'b1;
                  next_state = S_FETCH;
`endif
               end
            endcase
         end
         S_MEM: begin
            IorD = 1'b1;
            if (cls == C_LW) MemRead  = 1'b1;
            else             MemWrite = 1'b1;
            if (mem_ready) begin
               if (cls == C_LW) begin
                  next_state = S_WB;
               end else begin
                  instr_done = 1'b1;
                  next_state = S_FETCH;
               end
            end else if (timeout) begin
               next_state = S_HALT;
            end
         end
         S_WB: begin
            RegWrite   = 1'b1;
            RegDest    = (cls == C_R);
            MemtoReg   = (cls == C_LW);
            instr_done = 1'b1;
            next_state = S_FETCH;
         end
         S_HALT: next_state = S_HALT;
         default: next_state = S_RST;
      endcase
   end

   // wait_cnt only survives a cycle that stalls in place; any exit or ready clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_RST;
         op_q      <= '0;
         wait_cnt  <= '0;
         mem_err_q <= 1'b0;
      end else begin
         state_q <= next_state;
         if (state_q == S_DECODE) op_q <= OPCODE;
         if (waiting && !mem_ready && (next_state == state_q)) begin
            if (wait_cnt != '1) wait_cnt <= wait_cnt + CW'(1);
         end else begin
            wait_cnt <= '0;
         end
         if (timeout) mem_err_q <= 1'b1;
      end
   end

`ifdef ILLEGAL_OP_TRAP_EN
   logic illegal_q;
   assign illegal_op = illegal_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                 illegal_q <= 1'b0;
      else if (state_q == S_EXEC && cls == C_ILL) illegal_q <= 1'b1;
   end
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: an instruction-level model schedules the expected output vector of
// every cycle into exp_q; a negedge process compares the DUT against it. Honors ILLEGAL_OP_TRAP_EN.
module tb_multicycle_control_unit;

   localparam int OW = 5;
   localparam int WM = 15;

   localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_ILL = 5;

   typedef struct packed {
      logic [2:0] st;
      logic       pcw, br, pcs, iord, irw, mr, mw, m2r, rd, rw, sa;
      logic [1:0] sb, op;
      logic       done, err, ill;
   } vec_t;
   localparam int VW = $bits(vec_t);

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [OW-1:0] OPCODE = '0;
   logic          mem_ready = 1'b0;
   logic          PCWrite, Branch, PCSource, IorD, IRWrite, MemRead, MemWrite;
   logic          MemtoReg, RegDest, RegWrite, ALUSrcA, instr_done, mem_err;
   logic [1:0]    ALUSrcB, ALUOp;
   logic [2:0]    state;
   logic          ill_act;

   logic [VW-1:0] exp_q[$];
   string         tag_q[$];
   int            n_vec = 0;
   int            n_err = 0;
   logic          m_err = 1'b0;
   logic          m_ill = 1'b0;
   logic          halted = 1'b0;

   always #5 clk = ~clk;

   multicycle_control_unit #(.OPCODE_W(OW), .WAIT_MAX(WM)) dut (
      .clk(clk), .rst_n(rst_n), .OPCODE(OPCODE), .mem_ready(mem_ready),
      .PCWrite(PCWrite), .Branch(Branch), .PCSource(PCSource), .IorD(IorD),
      .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .RegDest(RegDest), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUOp(ALUOp), .instr_done(instr_done), .mem_err(mem_err),
`ifdef ILLEGAL_OP_TRAP_EN
      .illegal_op(ill_act),
`endif
      .state(state)
   );

`ifndef ILLEGAL_OP_TRAP_EN
   assign ill_act = 1'b0;
`endif

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         vec_t  e, a;
         string t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         a = {state, PCWrite, Branch, PCSource, IorD, IRWrite, MemRead, MemWrite, MemtoReg,
              RegDest, RegWrite, ALUSrcA, ALUSrcB, ALUOp, instr_done, mem_err, ill_act};
         n_vec++;
         if (a !== e) begin
            n_err++;
            $display("FAIL %s @%0t: got %b required %b", t, $time, a, e);
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: bench did not finish in time");
      $fatal(1);
   end

   function automatic int classify(input logic [OW-1:0] op);
      logic [3:0] lo;
      lo = op[3:0];
      if ((op >> 4) != '0) return K_ILL;
      case (lo)
         4'h0, 4'h1, 4'h2: return K_R;
         4'h9, 4'hA, 4'hB: return K_I;
         4'hC:             return K_LW;
         4'hD:             return K_SW;
         4'hF:             return K_BEQ;
         default:          return K_ILL;
      endcase
   endfunction

   function automatic vec_t mk(input logic [2:0] st);
      vec_t v;
      v     = '0;
      v.st  = st;
      v.err = m_err;
      v.ill = m_ill;
      return v;
   endfunction

   function automatic logic rand_rdy();
      return ($urandom_range(0, 3) != 0);
   endfunction

   function automatic logic [OW-1:0] rnd_op();
      return OW'($urandom);
   endfunction

   task automatic check_int(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s: got %0d required %0d", name, act, req);
      end
   endtask

   // One clock cycle: inputs applied just after the rising edge, expectation for that cycle queued.
   task automatic step(input logic rst, input logic rdy, input logic [OW-1:0] opc,
                       input vec_t e, input string tag);
      @(posedge clk);
      #1;
      rst_n     = rst;
      mem_ready = rdy;
      OPCODE    = opc;
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   task automatic do_reset();
      m_err  = 1'b0;
      m_ill  = 1'b0;
      halted = 1'b0;
      step(1'b0, rand_rdy(), rnd_op(), mk(3'd0), "reset");
      step(1'b0, rand_rdy(), rnd_op(), mk(3'd0), "reset");
      step(1'b1, rand_rdy(), rnd_op(), mk(3'd0), "reset_release");
   endtask

   task automatic do_halt();
      repeat (3) step(1'b1, rand_rdy(), rnd_op(), mk(3'd6), "halt");
      do_reset();
   endtask

   // fw/mw: forced number of not-ready cycles before ready in FETCH/MEM (-1 = random).
   task automatic do_instr(input logic [OW-1:0] op, input int fw, input int mw,
                           input bit abort, output int cyc);
      int   k;
      int   waits;
      logic rdy;
      vec_t v;
      k     = classify(op);
      cyc   = 0;
      waits = 0;
      forever begin
         rdy   = (fw >= 0) ? (waits >= fw) : rand_rdy();
         v     = mk(3'd1);
         v.mr  = 1'b1;
         v.sb  = 2'b01;
         v.pcw = rdy;
         v.irw = rdy;
         step(1'b1, rdy, rnd_op(), v, "fetch");
         cyc++;
         if (rdy) break;
         if (waits == WM) begin
            m_err  = 1'b1;
            halted = 1'b1;
            return;
         end
         waits++;
      end
      v    = mk(3'd2);
      v.sb = 2'b11;
      step(1'b1, rand_rdy(), op, v, "decode");
      cyc++;
      v = mk(3'd3);
      if (k != K_ILL) v.sa = 1'b1;
      case (k)
         K_R:        v.op = 2'b10;
         K_I:        begin v.sb = 2'b10; v.op = 2'b11; end
         K_LW, K_SW: v.sb = 2'b10;
         K_BEQ:      begin v.op = 2'b01; v.br = 1'b1; v.pcs = 1'b1; v.done = 1'b1; end
         default: begin
`ifndef ILLEGAL_OP_TRAP_EN
            v.done = 1'b1;
`endif
         end
      endcase
      step(1'b1, rand_rdy(), rnd_op(), v, "exec");
      cyc++;
      if (k == K_BEQ) return;
      if (k == K_ILL) begin
`ifdef ILLEGAL_OP_TRAP_EN
         m_ill  = 1'b1;
         halted = 1'b1;
`endif
         return;
      end
      if (k == K_LW || k == K_SW) begin
         waits = 0;
         forever begin
            rdy = abort ? 1'b0 : ((mw >= 0) ? (waits >= mw) : rand_rdy());
            v      = mk(3'd4);
            v.iord = 1'b1;
            v.mr   = (k == K_LW);
            v.mw   = (k == K_SW);
            v.done = (k == K_SW) && rdy;
            step(1'b1, rdy, rnd_op(), v, "mem");
            cyc++;
            if (abort) return;
            if (rdy) break;
            if (waits == WM) begin
               m_err  = 1'b1;
               halted = 1'b1;
               return;
            end
            waits++;
         end
         if (k == K_SW) return;
      end
      v      = mk(3'd5);
      v.rw   = 1'b1;
      v.rd   = (k == K_R);
      v.m2r  = (k == K_LW);
      v.done = 1'b1;
      step(1'b1, rand_rdy(), rnd_op(), v, "wb");
      cyc++;
   endtask

   initial begin
      int         c;
      logic [3:0] legal [10];
      logic [OW-1:0] op;
      legal = '{4'h0, 4'h1, 4'h2, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hF, 4'h7};

      do_reset();

      do_instr(5'b00001, 0, 0, 1'b0, c);     check_int("add_cycles", c, 4);
      do_instr(5'b01100, 0, 3, 1'b0, c);     check_int("lw_wait3_cycles", c, 8);
      do_instr(5'b01111, 0, 0, 1'b0, c);     check_int("beq_cycles", c, 3);
      do_instr(5'b01101, 0, 0, 1'b0, c);     check_int("sw_cycles", c, 4);
      do_instr(5'b01001, 0, 0, 1'b0, c);     check_int("addi_cycles", c, 4);
      do_instr(5'b00010, 0, 0, 1'b0, c);     check_int("shift_cycles", c, 4);
      do_instr(5'b01100, 0, 0, 1'b0, c);     check_int("lw_cycles", c, 5);
      do_instr(5'b00001, 15, 0, 1'b0, c);    check_int("fetch_wait15_cycles", c, 19);
      check_int("no_timeout_at_limit", int'(m_err), 0);

      do_instr(5'b01101, 0, 0, 1'b1, c);     check_int("sw_abort_cycles", c, 4);
      do_reset();

      do_instr(5'b00111, 0, 0, 1'b0, c);
`ifdef ILLEGAL_OP_TRAP_EN
      check_int("trap_cycles", c, 3);
      check_int("trap_halted", int'(halted), 1);
      do_halt();
`else
      check_int("nop_cycles", c, 3);
      check_int("nop_not_halted", int'(halted), 0);
`endif
      do_instr(5'b10001, 0, 0, 1'b0, c);
      check_int("upper_bit_illegal_cycles", c, 3);
      if (halted) do_halt();

      do_instr(5'b00001, 1000, 0, 1'b0, c);
      check_int("fetch_timeout_cycles", c, 16);
      check_int("fetch_timeout_err", int'(m_err), 1);
      do_halt();

      do_instr(5'b01100, 0, 1000, 1'b0, c);
      check_int("mem_timeout_cycles", c, 19);
      check_int("mem_timeout_err", int'(m_err), 1);
      do_halt();

      repeat (300) begin
         if ($urandom_range(0, 9) == 0) op = rnd_op();
         else op = {1'b0, legal[$urandom_range(0, 9)]};
         do_instr(op, -1, -1, ($urandom_range(0, 39) == 0), c);
         if (halted) do_halt();
         else if (c > 0 && exp_q.size() >= 0 && tag_q.size() > 0 && tag_q[tag_q.size()-1] == "mem"
                  && classify(op) == K_SW && state === 3'd4) begin
            do_reset();
         end
      end

      repeat (3) @(negedge clk);
      check_int("queue_drained", exp_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
